fetcher_icache: RTL and testbench

- Per-core instruction fetch stage, directly upstream of the core scheduler.
- Fetches the instruction at current_pc when the core is in FETCH and reports progress on fetcher_state, which the scheduler polls to move FETCH->DECODE.
- Adds a small direct-mapped instruction cache, so repeated loop bodies skip the program-memory round trip.
- Talks to the program-memory controller through a valid/ready read channel.

---
 rtl/gpu_pkg.sv | 25 ++
 rtl/icache_array.sv | 59 +++++
 rtl/fetcher_icache.sv | 103 ++++++++++
 tb/tb_fetcher_icache.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared encodings and defaults for the GPU core front end.
`timescale 1ns/1ps
package gpu_pkg;

  localparam int unsigned PROGRAM_MEM_ADDR_BITS_DEFAULT = 8;
  localparam int unsigned PROGRAM_MEM_DATA_BITS_DEFAULT = 16;
  localparam int unsigned COUNT_BITS                    = 16;

  // Scheduler states the fetcher reacts to
  localparam logic [2:0] CORE_STATE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_STATE_DECODE = 3'b010;

  // Progress reported back to the scheduler
  typedef enum logic [2:0] {
    FETCHER_IDLE     = 3'b000,
    FETCHER_FETCHING = 3'b001,
    FETCHER_FETCHED  = 3'b010
  } fetcher_state_t;

  // Saturating increment for the hit/miss statistics
  function automatic logic [COUNT_BITS-1:0] sat_inc(input logic [COUNT_BITS-1:0] value);
    return (value == '1) ? value : value + COUNT_BITS'(1);
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped, one-instruction-per-line storage: valid/tag/data arrays with
// a combinational lookup port, one write port and a synchronous flush.
`timescale 1ns/1ps
module icache_array #(
  parameter int unsigned ADDR_BITS = 8,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned LINES     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [ADDR_BITS-1:0] lookup_addr,
  output logic                 lookup_hit_c,
  output logic [DATA_BITS-1:0] lookup_data_c,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [DATA_BITS-1:0] wr_data
);

  localparam int unsigned INDEX_BITS = $clog2(LINES);
  localparam int unsigned TAG_BITS   = ADDR_BITS - INDEX_BITS;

  logic [LINES-1:0]     valid_q;
  logic [TAG_BITS-1:0]  tag_q  [LINES];
  logic [DATA_BITS-1:0] data_q [LINES];

  logic [INDEX_BITS-1:0] lookup_index;
  logic [TAG_BITS-1:0]   lookup_tag;
  logic [INDEX_BITS-1:0] wr_index;
  logic [TAG_BITS-1:0]   wr_tag;

  assign lookup_index = lookup_addr[INDEX_BITS-1:0];
  assign lookup_tag   = lookup_addr[ADDR_BITS-1:INDEX_BITS];
  assign wr_index     = wr_addr[INDEX_BITS-1:0];
  assign wr_tag       = wr_addr[ADDR_BITS-1:INDEX_BITS];

  assign lookup_hit_c  = valid_q[lookup_index] && (tag_q[lookup_index] == lookup_tag);
  assign lookup_data_c = data_q[lookup_index];

  // Valid bits: flush beats a same-cycle write
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data arrays are not reset; valid bits gate their use
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_data;
    end
  end

endmodule

// File: rtl/fetcher_icache.sv
// Per-core instruction fetch stage with a small direct-mapped instruction
// cache in front of the program-memory valid/ready read channel.
`timescale 1ns/1ps
module fetcher_icache
  import gpu_pkg::*;
#(
  parameter int unsigned PROGRAM_MEM_ADDR_BITS = PROGRAM_MEM_ADDR_BITS_DEFAULT,
  parameter int unsigned PROGRAM_MEM_DATA_BITS = PROGRAM_MEM_DATA_BITS_DEFAULT,
  parameter int unsigned CACHE_LINES           = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             flush,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  output logic                             mem_read_valid,
  output logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                             mem_read_ready,
  input  logic [PROGRAM_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [COUNT_BITS-1:0]            hit_count,
  output logic [COUNT_BITS-1:0]            miss_count
);

  fetcher_state_t                   state_q;
  logic                             fill_poisoned_q;
  logic                             lookup_hit_c;
  logic [PROGRAM_MEM_DATA_BITS-1:0] lookup_data_c;
  logic                             fill_write_c;

  assign fetcher_state = state_q;

  // A fill that saw a flush still returns its instruction but never installs the line
  assign fill_write_c = (state_q == FETCHER_FETCHING) && mem_read_ready && !fill_poisoned_q;

  icache_array #(
    .ADDR_BITS (PROGRAM_MEM_ADDR_BITS),
    .DATA_BITS (PROGRAM_MEM_DATA_BITS),
    .LINES     (CACHE_LINES)
  ) u_icache_array (
    .clk           (clk),
    .reset         (reset),
    .flush         (flush),
    .lookup_addr   (current_pc),
    .lookup_hit_c  (lookup_hit_c),
    .lookup_data_c (lookup_data_c),
    .wr_en         (fill_write_c),
    .wr_addr       (mem_read_address),
    .wr_data       (mem_read_data)
  );

  // Fetch FSM, memory handshake and hit/miss statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= FETCHER_IDLE;
      mem_read_valid   <= 1'b0;
      mem_read_address <= '0;
      instruction      <= '0;
      hit_count        <= '0;
      miss_count       <= '0;
      fill_poisoned_q  <= 1'b0;
    end else begin
      case (state_q)
        FETCHER_IDLE: begin
          if (core_state == CORE_STATE_FETCH) begin
            if (lookup_hit_c && !flush) begin
              instruction <= lookup_data_c;
              hit_count   <= sat_inc(hit_count);
              state_q     <= FETCHER_FETCHED;
            end else begin
              mem_read_valid   <= 1'b1;
              mem_read_address <= current_pc;
              miss_count       <= sat_inc(miss_count);
              fill_poisoned_q  <= 1'b0;
              state_q          <= FETCHER_FETCHING;
            end
          end
        end
        FETCHER_FETCHING: begin
          if (flush) begin
            fill_poisoned_q <= 1'b1;
          end
          if (mem_read_ready) begin
            instruction    <= mem_read_data;
            mem_read_valid <= 1'b0;
            state_q        <= FETCHER_FETCHED;
          end
        end
        FETCHER_FETCHED: begin
          if (core_state == CORE_STATE_DECODE) begin
            state_q <= FETCHER_IDLE;
          end
        end
        default: begin
          mem_read_valid <= 1'b0;
          state_q        <= FETCHER_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetcher_icache.sv
// Randomized scoreboard bench for fetcher_icache against a line-level cache model.
`timescale 1ns/1ps
module tb_fetcher_icache;

  localparam logic [2:0] S_IDLE     = 3'b000;
  localparam logic [2:0] S_FETCHING = 3'b001;
  localparam logic [2:0] S_FETCHED  = 3'b010;
  localparam logic [2:0] C_FETCH    = 3'b001;
  localparam logic [2:0] C_DECODE   = 3'b010;
  localparam logic [2:0] C_OTHER    = 3'b000;
  localparam int         LINES      = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [2:0]  core_state = C_OTHER;
  logic [7:0]  current_pc = 8'h00;
  logic        mem_read_valid;
  logic [7:0]  mem_read_address;
  logic        mem_read_ready = 1'b0;
  logic [15:0] mem_read_data = 16'h0000;
  logic [2:0]  fetcher_state;
  logic [15:0] instruction;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  fetcher_icache #(
    .PROGRAM_MEM_ADDR_BITS (8),
    .PROGRAM_MEM_DATA_BITS (16),
    .CACHE_LINES           (LINES)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .core_state       (core_state),
    .current_pc       (current_pc),
    .mem_read_valid   (mem_read_valid),
    .mem_read_address (mem_read_address),
    .mem_read_ready   (mem_read_ready),
    .mem_read_data    (mem_read_data),
    .fetcher_state    (fetcher_state),
    .instruction      (instruction),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] data;
    bit          hit;
    int          hits;
    int          misses;
  } exp_t;

  exp_t        q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Program memory and the reference cache: which pc each line holds, if any
  logic [15:0] prog [256];
  bit          mvalid [LINES];
  logic [7:0]  mpc [LINES];
  int          mhits = 0;
  int          mmisses = 0;

  int          resp_lat = 1;
  bit          resp_off = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic abort_run(input string why);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", why, $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  task automatic model_flush();
    for (int i = 0; i < LINES; i++) mvalid[i] = 1'b0;
  endtask

  task automatic flush_pulse();
    @(negedge clk);
    flush = 1'b1;
    model_flush();
    @(negedge clk);
    flush = 1'b0;
  endtask

  // flush_mode: 0 none, 1 random during fill/hold, 2 on first fill cycle, 3 with the lookup
  task automatic do_fetch(input logic [7:0] pc, input int lat, input int flush_mode);
    exp_t e;
    int   idx;
    bit   hit;
    bit   poisoned;
    int   cycles;
    int   hold;
    idx      = int'(pc) % LINES;
    poisoned = 1'b0;
    cycles   = 0;
    @(negedge clk);
    resp_lat   = lat;
    core_state = C_FETCH;
    current_pc = pc;
    hit = (flush_mode != 3) && mvalid[idx] && (mpc[idx] == pc);
    if (flush_mode == 3) begin
      flush = 1'b1;
      model_flush();
      poisoned = 1'b1;
    end
    if (hit) mhits++; else mmisses++;
    e.pc = pc; e.data = prog[pc]; e.hit = hit; e.hits = mhits; e.misses = mmisses;
    q.push_back(e);
    forever begin
      @(negedge clk);
      flush = 1'b0;
      if (fetcher_state == S_FETCHED) break;
      cycles++;
      if (cycles > 40) abort_run("fetch_timeout");
      if (fetcher_state == S_FETCHING &&
          ((flush_mode == 2 && cycles == 1) || (flush_mode == 1 && $urandom_range(0, 3) == 0))) begin
        flush = 1'b1;
        model_flush();
        poisoned = 1'b1;
      end
    end
    check("fetch_latency", 32'(cycles), hit ? 32'd0 : 32'(lat));
    if (!hit && !poisoned) begin
      mvalid[idx] = 1'b1;
      mpc[idx]    = pc;
    end
    hold = $urandom_range(0, 2);
    repeat (hold) begin
      @(negedge clk);
      flush = 1'b0;
      if (flush_mode == 1 && $urandom_range(0, 3) == 0) begin
        flush = 1'b1;
        model_flush();
      end
    end
    @(negedge clk);
    flush      = 1'b0;
    core_state = C_DECODE;
    @(negedge clk);
    check("back_to_idle", 32'(fetcher_state), 32'(S_IDLE));
    core_state = C_OTHER;
  endtask

  // Program-memory responder: ready after resp_lat cycles of valid
  initial begin
    bit busy;
    int cnt;
    busy = 1'b0;
    cnt  = 0;
    forever begin
      @(negedge clk);
      if (resp_off) continue;
      mem_read_ready = 1'b0;
      mem_read_data  = 16'($urandom);
      if (reset) begin
        busy = 1'b0;
        continue;
      end
      if (mem_read_valid) begin
        if (!busy) begin
          busy = 1'b1;
          cnt  = resp_lat - 1;
        end
        if (cnt == 0) begin
          mem_read_ready = 1'b1;
          mem_read_data  = prog[mem_read_address];
          busy           = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: checks request address, completed fetches and output stability
  initial begin
    logic [2:0]  prev;
    bit          saw_req;
    logic [15:0] last_instr;
    exp_t        e;
    prev       = S_IDLE;
    saw_req    = 1'b0;
    last_instr = 16'h0000;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev    = S_IDLE;
        saw_req = 1'b0;
        continue;
      end
      if (mem_read_valid) begin
        saw_req = 1'b1;
        if (q.size() > 0) check("req_address", 32'(mem_read_address), 32'(q[0].pc));
      end
      if (fetcher_state == S_FETCHED && prev != S_FETCHED) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_fetched: state FETCHED with no fetch outstanding at %0t", $time);
        end else begin
          e = q.pop_front();
          check("instruction", 32'(instruction), 32'(e.data));
          check("hit_count", 32'(hit_count), 32'(e.hits));
          check("miss_count", 32'(miss_count), 32'(e.misses));
          if (e.hit) check("hit_without_request", 32'(saw_req), 32'd0);
        end
        saw_req    = 1'b0;
        last_instr = instruction;
      end else if (fetcher_state == S_FETCHED) begin
        check("instruction_stable", 32'(instruction), 32'(last_instr));
      end
      prev = fetcher_state;
    end
  end

  initial begin
    #2ms;
    abort_run("global_timeout");
  end

  logic [7:0] pool [8];

  initial begin
    int waited;
    for (int i = 0; i < 256; i++) prog[i] = 16'($urandom);
    prog[8'h10] = 16'hABCD;
    for (int i = 0; i < LINES; i++) begin
      mvalid[i] = 1'b0;
      mpc[i]    = 8'h00;
    end
    pool[0] = 8'h10; pool[1] = 8'h14; pool[2] = 8'h20; pool[3] = 8'h24;
    pool[4] = 8'h11; pool[5] = 8'h31; pool[6] = 8'h03; pool[7] = 8'h07;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_state", 32'(fetcher_state), 32'(S_IDLE));
    check("rst_valid", 32'(mem_read_valid), 32'd0);
    check("rst_address", 32'(mem_read_address), 32'd0);
    check("rst_instruction", 32'(instruction), 32'd0);
    check("rst_hits", 32'(hit_count), 32'd0);
    check("rst_misses", 32'(miss_count), 32'd0);
    reset = 1'b0;

    // Cold miss, warm hit, conflict, same-cycle ready
    flush_pulse();
    do_fetch(8'h10, 3, 0);
    do_fetch(8'h10, 1, 0);
    do_fetch(8'h14, 2, 0);
    do_fetch(8'h10, 1, 0);
    do_fetch(8'h10, 4, 0);

    // Flush during fill delivers but does not install; flush with lookup forces a miss
    do_fetch(8'h20, 3, 2);
    do_fetch(8'h20, 1, 0);
    do_fetch(8'h20, 2, 0);
    do_fetch(8'h20, 2, 3);
    flush_pulse();

    // Randomized mix with random flushes
    for (int n = 0; n < 150; n++) begin
      logic [7:0] pc;
      int         mode;
      pc   = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : pool[$urandom_range(0, 7)];
      mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
      do_fetch(pc, $urandom_range(1, 4), mode);
      if ($urandom_range(0, 15) == 0) flush_pulse();
    end
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);

    // Reset while a fill is outstanding; a late ready must be ignored
    resp_off       = 1'b1;
    mem_read_ready = 1'b0;
    @(negedge clk);
    core_state = C_FETCH;
    current_pc = 8'h40;
    waited     = 0;
    do begin
      @(negedge clk);
      waited++;
      if (waited > 5) abort_run("reset_test_no_fetching");
    end while (fetcher_state != S_FETCHING);
    reset      = 1'b1;
    core_state = C_OTHER;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_valid", 32'(mem_read_valid), 32'd0);
    check("rstmid_state", 32'(fetcher_state), 32'(S_IDLE));
    check("rstmid_hits", 32'(hit_count), 32'd0);
    check("rstmid_misses", 32'(miss_count), 32'd0);
    mem_read_ready = 1'b1;
    mem_read_data  = 16'h5A5A;
    repeat (2) begin
      @(negedge clk);
      check("late_ready_state", 32'(fetcher_state), 32'(S_IDLE));
      check("late_ready_instruction", 32'(instruction), 32'd0);
      check("late_ready_valid", 32'(mem_read_valid), 32'd0);
    end
    mem_read_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
